// File: rtl/color_blob_locator.sv
// color_blob_locator
// Watches a raster pixel stream. Once per frame it reports the centre of the
// bounding box that contains every pixel matching a target colour.
//
// Ports:
//   clk        pixel clock; every register updates on its rising edge
//   reset_n    synchronous reset, active low
//   hcount     current column; values >= H_ACTIVE are blanking
//   vcount     current row; values >= V_ACTIVE are blanking
//   pixel      RGB 3:3:3 pixel value
//   color      target colour
//   mask       per-bit compare mask; a 0 bit is ignored in the compare
//   enable     detection enable; only its value at frame start matters
//   x_loc      reported blob centre column
//   y_loc      reported blob centre row
//   found      the last report had at least MIN_COUNT matching pixels
//   pix_count  matching-pixel count of the last report, saturating
//   loc_valid  one-cycle strobe for each completed frame
module color_blob_locator #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int MIN_COUNT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic [8:0]  pixel,
  input  logic [8:0]  color,
  input  logic [8:0]  mask,
  input  logic        enable,
  output logic [9:0]  x_loc,
  output logic [9:0]  y_loc,
  output logic        found,
  output logic [15:0] pix_count,
  output logic        loc_valid
);

  localparam logic [9:0]  H_END  = 10'(H_ACTIVE);
  localparam logic [9:0]  V_END  = 10'(V_ACTIVE);
  localparam logic [9:0]  H_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);
  localparam logic [15:0] MIN_CNT = 16'(MIN_COUNT);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_REPORT} state_t;

  // Stage 1: the pixel classification, registered.
  logic       match_d, sof_d, eof_d;
  logic       match_q, sof_q, eof_q, en_q;
  logic [9:0] h_q, v_q;

  // Stage 2: the FSM, the accumulators and the output registers.
  state_t      state_d, state_q;
  logic [9:0]  min_x_d, min_x_q, max_x_d, max_x_q;
  logic [9:0]  min_y_d, min_y_q, max_y_d, max_y_q;
  logic [15:0] cnt_d, cnt_q;
  logic [9:0]  x_loc_d, x_loc_q, y_loc_d, y_loc_q;
  logic        found_d, found_q, loc_valid_d, loc_valid_q;
  logic [15:0] pix_count_d, pix_count_q;

  logic        restart, update, take;
  logic [9:0]  b_min_x, b_max_x, b_min_y, b_max_y;
  logic [15:0] b_cnt;

  always_comb begin
    match_d = (((pixel ^ color) & mask) == 9'd0) && (hcount < H_END) && (vcount < V_END);
    sof_d   = (hcount == 10'd0) && (vcount == 10'd0);
    eof_d   = (hcount == H_LAST) && (vcount == V_LAST);
  end

  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    update  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sof_q && en_q) begin
          restart = 1'b1;
          state_d = eof_q ? S_REPORT : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (sof_q) begin
          // A SOF seen here means the frame was truncated or a new frame
          // started. Either way the accumulators start again.
          if (en_q) begin
            restart = 1'b1;
            state_d = eof_q ? S_REPORT : S_ACCUM;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          update = 1'b1;
          if (eof_q) state_d = S_REPORT;
        end
      end
      S_REPORT: begin
        // The outputs read the accumulators during this cycle, so the clear
        // does not disturb them. A back-to-back SOF is in stage 2 during
        // this same cycle and is taken as the first pixel of the new frame.
        restart = 1'b1;
        if (en_q) state_d = (sof_q && eof_q) ? S_REPORT : S_ACCUM;
        else      state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    b_min_x = restart ? 10'h3FF : min_x_q;
    b_max_x = restart ? 10'h000 : max_x_q;
    b_min_y = restart ? 10'h3FF : min_y_q;
    b_max_y = restart ? 10'h000 : max_y_q;
    b_cnt   = restart ? 16'h0000 : cnt_q;
    // On a restart only the SOF pixel itself can be accumulated.
    take    = match_q && (restart ? sof_q : update);
    min_x_d = b_min_x;
    max_x_d = b_max_x;
    min_y_d = b_min_y;
    max_y_d = b_max_y;
    cnt_d   = b_cnt;
    if (take) begin
      min_x_d = (h_q < b_min_x) ? h_q : b_min_x;
      max_x_d = (h_q > b_max_x) ? h_q : b_max_x;
      min_y_d = (v_q < b_min_y) ? v_q : b_min_y;
      max_y_d = (v_q > b_max_y) ? v_q : b_max_y;
      cnt_d   = (b_cnt == 16'hFFFF) ? b_cnt : b_cnt + 16'd1;
    end
  end

  always_comb begin
    x_loc_d     = x_loc_q;
    y_loc_d     = y_loc_q;
    found_d     = found_q;
    pix_count_d = pix_count_q;
    loc_valid_d = 1'b0;
    if (state_q == S_REPORT) begin
      loc_valid_d = 1'b1;
      pix_count_d = cnt_q;
      found_d     = (cnt_q >= MIN_CNT);
      if (cnt_q >= MIN_CNT) begin
        // Add in 11 bits so the carry is kept, halve, then keep 10 bits.
        x_loc_d = 10'((11'(min_x_q) + 11'(max_x_q)) >> 1);
        y_loc_d = 10'((11'(min_y_q) + 11'(max_y_q)) >> 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      match_q     <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      en_q        <= 1'b0;
      h_q         <= 10'd0;
      v_q         <= 10'd0;
      state_q     <= S_IDLE;
      min_x_q     <= 10'h3FF;
      max_x_q     <= 10'h000;
      min_y_q     <= 10'h3FF;
      max_y_q     <= 10'h000;
      cnt_q       <= 16'd0;
      x_loc_q     <= 10'd0;
      y_loc_q     <= 10'd0;
      found_q     <= 1'b0;
      pix_count_q <= 16'd0;
      loc_valid_q <= 1'b0;
    end else begin
      match_q     <= match_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      en_q        <= enable;
      h_q         <= hcount;
      v_q         <= vcount;
      state_q     <= state_d;
      min_x_q     <= min_x_d;
      max_x_q     <= max_x_d;
      min_y_q     <= min_y_d;
      max_y_q     <= max_y_d;
      cnt_q       <= cnt_d;
      x_loc_q     <= x_loc_d;
      y_loc_q     <= y_loc_d;
      found_q     <= found_d;
      pix_count_q <= pix_count_d;
      loc_valid_q <= loc_valid_d;
    end
  end

  assign x_loc     = x_loc_q;
  assign y_loc     = y_loc_q;
  assign found     = found_q;
  assign pix_count = pix_count_q;
  assign loc_valid = loc_valid_q;

endmodule

// File: tb/tb_color_blob_locator.sv
// Bench for color_blob_locator. The frame is made small (32x24 active, with
// blanking columns at hcount 700+ and blanking rows at vcount 500+) so that
// many frames fit in the run time. Two instances take the same stream: one
// with MIN_COUNT=4 and one with MIN_COUNT=1. A reference model computes each
// report from the frame image. A monitor compares every loc_valid pulse, and
// its timing, with the model.
module tb_color_blob_locator;
  localparam int H_A = 32, V_A = 24, H_BL = 4, V_BL = 2;
  localparam int H_T = H_A + H_BL, V_T = V_A + V_BL;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  hcount = 10'd700, vcount = 10'd500;
  logic [8:0]  pixel = 9'd0, color = 9'h1C0, mask = 9'h1FF;
  logic        enable = 1'b0;
  logic [9:0]  x_loc0, y_loc0, x_loc1, y_loc1;
  logic        found0, found1, loc_valid0, loc_valid1;
  logic [15:0] pix_count0, pix_count1;

  color_blob_locator #(.H_ACTIVE(H_A), .V_ACTIVE(V_A), .MIN_COUNT(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .hcount(hcount), .vcount(vcount), .pixel(pixel),
    .color(color), .mask(mask), .enable(enable), .x_loc(x_loc0), .y_loc(y_loc0),
    .found(found0), .pix_count(pix_count0), .loc_valid(loc_valid0));

  color_blob_locator #(.H_ACTIVE(H_A), .V_ACTIVE(V_A), .MIN_COUNT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .hcount(hcount), .vcount(vcount), .pixel(pixel),
    .color(color), .mask(mask), .enable(enable), .x_loc(x_loc1), .y_loc(y_loc1),
    .found(found1), .pix_count(pix_count1), .loc_valid(loc_valid1));

  always #5 clk = ~clk;

  int pe = 0;
  always @(posedge clk) pe <= pe + 1;

  int n_checks = 0, n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d required %0d (edge %0d)", tag, obs, exp, pe);
    end
  endtask

  typedef struct {
    int          due;
    logic [9:0]  x0, y0, x1, y1;
    logic        f0, f1;
    logic [15:0] cnt;
  } exp_t;
  exp_t exp_q[$];

  logic [8:0] img [0:V_T-1][0:H_T-1];
  logic [9:0] held_x [2];
  logic [9:0] held_y [2];

  // Reference model: the bounding box and count of the matching pixels in
  // the active area, taken directly from the match rule.
  function automatic exp_t model_report(input int due);
    exp_t e;
    int cnt = 0, mnx = 1023, mxx = 0, mny = 1023, mxy = 0;
    int mins [2];
    logic [9:0] ex [2];
    logic [9:0] ey [2];
    logic ef [2];
    mins[0] = 4;
    mins[1] = 1;
    for (int v = 0; v < V_A; v++)
      for (int h = 0; h < H_A; h++)
        if (((img[v][h] ^ color) & mask) == 9'd0) begin
          cnt++;
          if (h < mnx) mnx = h;
          if (h > mxx) mxx = h;
          if (v < mny) mny = v;
          if (v > mxy) mxy = v;
        end
    for (int k = 0; k < 2; k++) begin
      ef[k] = (cnt >= mins[k]);
      if (ef[k]) begin
        held_x[k] = 10'((mnx + mxx) / 2);
        held_y[k] = 10'((mny + mxy) / 2);
      end
      ex[k] = held_x[k];
      ey[k] = held_y[k];
    end
    e.due = due;
    e.x0 = ex[0]; e.y0 = ey[0]; e.f0 = ef[0];
    e.x1 = ex[1]; e.y1 = ey[1]; e.f1 = ef[1];
    e.cnt = 16'(cnt);
    return e;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due == pe) begin
      $display("report edge %0d: x0=%0d y0=%0d f0=%0d x1=%0d y1=%0d f1=%0d cnt=%0d",
               pe, x_loc0, y_loc0, found0, x_loc1, y_loc1, found1, pix_count0);
      chk("loc_valid0", loc_valid0, 1);
      chk("loc_valid1", loc_valid1, 1);
      chk("x_loc0", x_loc0, exp_q[0].x0);
      chk("y_loc0", y_loc0, exp_q[0].y0);
      chk("found0", found0, exp_q[0].f0);
      chk("pix_count0", pix_count0, exp_q[0].cnt);
      chk("x_loc1", x_loc1, exp_q[0].x1);
      chk("y_loc1", y_loc1, exp_q[0].y1);
      chk("found1", found1, exp_q[0].f1);
      chk("pix_count1", pix_count1, exp_q[0].cnt);
      void'(exp_q.pop_front());
    end else if (loc_valid0 || loc_valid1) begin
      chk("unexpected_loc_valid", {loc_valid0, loc_valid1}, 0);
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_x0"}, x_loc0, 0);
    chk({tag, "_y0"}, y_loc0, 0);
    chk({tag, "_f0"}, found0, 0);
    chk({tag, "_cnt0"}, pix_count0, 0);
    chk({tag, "_x1"}, x_loc1, 0);
    chk({tag, "_cnt1"}, pix_count1, 0);
  endtask

  task automatic fill(input logic [8:0] bg);
    for (int v = 0; v < V_T; v++)
      for (int h = 0; h < H_T; h++)
        img[v][h] = bg;
  endtask

  // Drives one frame. en_sof is the enable value with the SOF pixel, and
  // en_mid is the value from mid-frame on. b2b stops right after the EOF
  // pixel, so the next SOF comes on the following cycle. rst_row >= 0
  // pulses reset_n low for one pixel at the start of that row.
  task automatic run_frame(input bit en_sof, input bit en_mid, input bit b2b, input int rst_row);
    bit rst_pend = 0;
    bit report = en_sof && (rst_row < 0);
    for (int v = 0; v < V_T; v++) begin
      for (int h = 0; h < H_T; h++) begin
        @(negedge clk);
        if (rst_pend) begin
          check_reset_outputs("mid_reset");
          rst_pend = 0;
        end
        hcount  = (h < H_A) ? 10'(h) : 10'(700 + h - H_A);
        vcount  = (v < V_A) ? 10'(v) : 10'(500 + v - V_A);
        pixel   = img[v][h];
        enable  = (v >= V_A / 2) ? en_mid : en_sof;
        reset_n = !(v == rst_row && h == 0);
        if (v == rst_row && h == 0) begin
          rst_pend = 1;
          for (int k = 0; k < 2; k++) begin
            held_x[k] = 10'd0;
            held_y[k] = 10'd0;
          end
        end
        if (v == V_A - 1 && h == H_A - 1) begin
          if (report) exp_q.push_back(model_report(pe + 3));
          if (b2b) return;
        end
      end
    end
  endtask

  initial begin
    logic [8:0] lowbit, mval;
    held_x[0] = 0; held_x[1] = 0; held_y[0] = 0; held_y[1] = 0;
    fill(9'd0);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // 4x4 blob of 1C0 with its top-left at (10,12). Centre (11,13), count 16.
    color = 9'h1C0; mask = 9'h1FF;
    fill(9'd0);
    for (int v = 12; v < 16; v++)
      for (int h = 10; h < 14; h++)
        img[v][h] = 9'h1C0;
    run_frame(1, 1, 0, -1);

    // One matching pixel on the EOF position, followed by a back-to-back frame.
    fill(9'd0);
    img[V_A-1][H_A-1] = 9'h1C0;
    run_frame(1, 1, 1, -1);

    // Three matching pixels: found=0 on the MIN_COUNT=4 instance, and the
    // location holds its previous value.
    fill(9'd0);
    img[2][3] = 9'h1C0; img[7][20] = 9'h1C0; img[15][5] = 9'h1C0;
    run_frame(1, 1, 0, -1);

    // Masked compare: only the red bits matter. Matching values in the
    // blanking columns (hcount 700+) must not be counted.
    color = 9'h1C0; mask = 9'h1C0;
    fill(9'h03F);
    img[10][10] = 9'h1C7; img[20][20] = 9'h1C7;
    for (int v = 0; v < V_T; v++)
      for (int h = H_A; h < H_T; h++)
        img[v][h] = 9'h1C7;
    run_frame(1, 1, 0, -1);

    // Reset for one cycle mid-frame, then a clean frame.
    color = 9'h1C0; mask = 9'h1FF;
    fill(9'd0);
    for (int v = 12; v < 16; v++)
      for (int h = 10; h < 14; h++)
        img[v][h] = 9'h1C0;
    run_frame(1, 1, 0, 5);
    run_frame(1, 1, 0, -1);

    // Enable behaviour: only its value at SOF decides whether a frame reports.
    run_frame(1, 0, 0, -1);
    run_frame(0, 0, 0, -1);
    run_frame(0, 1, 0, -1);
    run_frame(1, 1, 0, -1);

    // Randomized frames.
    for (int f = 0; f < 16; f++) begin
      int x0, x1, y0, y1, dens;
      color = 9'($urandom);
      mask  = 9'($urandom) | 9'(1 << $urandom_range(0, 8));
      lowbit = mask & (~mask + 9'd1);
      x0 = $urandom_range(0, H_A - 1); x1 = $urandom_range(x0, H_A - 1);
      y0 = $urandom_range(0, V_A - 1); y1 = $urandom_range(y0, V_A - 1);
      dens = $urandom_range(0, 2);
      for (int v = 0; v < V_T; v++)
        for (int h = 0; h < H_T; h++) begin
          mval = color ^ (9'($urandom) & ~mask);
          if (v >= V_A || h >= H_A)
            img[v][h] = 9'($urandom);
          else if (h >= x0 && h <= x1 && v >= y0 && v <= y1 &&
                   (dens == 0 || (dens == 1 && $urandom_range(0, 3) == 0) ||
                    (dens == 2 && $urandom_range(0, 63) == 0)))
            img[v][h] = mval;
          else
            img[v][h] = mval ^ lowbit;
        end
      run_frame($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), -1);
    end

    @(negedge clk);
    hcount = 10'd700; vcount = 10'd500;
    repeat (6) @(negedge clk);
    chk("pending_reports", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/color_blob_locator.md
# color_blob_locator

Consumes the raster pixel stream (hcount, vcount, 9-bit RGB pixel) and, once per frame, reports the centre of the bounding box of all pixels matching a target colour. It is the detection counterpart of the blob renderer: the renderer paints a blob at (x_loc, y_loc); this block recovers (x_loc, y_loc) from a captured frame. It sits between the camera/frame-buffer readout and the game/projector logic.

## Interface
- H_ACTIVE, 640: active pixels per line; hcount >= H_ACTIVE is blanking.
- V_ACTIVE, 480: active lines per frame; vcount >= V_ACTIVE is blanking.
- MIN_COUNT, 4: minimum matching pixels for a valid detection.

- clk  in  1  pixel clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- hcount  in  10  current pixel column.
- vcount  in  10  current pixel row.
- pixel  in  9  pixel colour, RGB 3:3:3.
- color  in  9  target colour.
- mask  in  9  per-bit compare mask; a 0 bit is don't-care.
- enable  in  1  detection enable, sampled at frame start.
- x_loc  out  10  reported blob centre column.
- y_loc  out  10  reported blob centre row.
- found  out  1  last report met MIN_COUNT.
- pix_count  out  16  matching-pixel count of the last reported frame, saturating.
- loc_valid  out  1  one-cycle strobe per completed frame.

## Operation
- Match: ((pixel ^ color) & mask) == 0 and hcount < H_ACTIVE and vcount < V_ACTIVE. Blanking pixels never match.
- Frame start (SOF): hcount == 0 and vcount == 0. Frame end (EOF): hcount == H_ACTIVE-1 and vcount == V_ACTIVE-1.
- Stage 1 registers match, hcount, vcount, SOF and EOF. Stage 2 updates the accumulators.
- Accumulators:
  - min_x and min_y initialise to 10'h3FF; max_x and max_y initialise to 0.
  - cnt is 16 bits and saturates at 16'hFFFF.
  - All accumulators reinitialise on a registered SOF, and the SOF pixel itself is accumulated.
- States:
  - IDLE: accumulators are not updated. Go to ACCUM on a registered SOF with enable = 1.
  - ACCUM: update on each registered match. Go to REPORT on a registered EOF. Go to IDLE if enable = 0 is sampled on any registered SOF. A new SOF while in ACCUM (truncated frame) restarts the accumulators and produces no report.
  - REPORT: lasts one cycle, then goes to ACCUM if enable = 1, else IDLE.
- REPORT behaviour:
  - If cnt >= MIN_COUNT: x_loc = (min_x + max_x) >> 1 and y_loc = (min_y + max_y) >> 1, summed in 11 bits and truncated. found = 1.
  - Otherwise x_loc and y_loc hold their previous values and found = 0.
  - pix_count = cnt in either case.
  - loc_valid pulses in either case.
- Outputs hold between reports.
- enable deasserted mid-frame does not abort the frame. It is honoured at the next SOF only.

## Timing
- Reset values: x_loc = 0, y_loc = 0, found = 0, pix_count = 0, loc_valid = 0, state IDLE, accumulators at their init values.
- Latency: if the EOF pixel is presented in cycle N, then x_loc, y_loc, found, pix_count and loc_valid all update at the edge ending cycle N+2. They are visible in cycle N+3, and loc_valid is high for cycle N+3 only.
- Throughput: one pixel per clock, no stalls. hcount and vcount may advance every cycle.
- Back-to-back frames: a SOF arriving one cycle after EOF is accepted; the REPORT cycle overlaps stage 1 of the new frame.
- Reset mid-frame: all in-flight state is discarded, no report is produced, and the block needs a fresh SOF to begin.
- EOF without a preceding SOF (block in IDLE) is ignored.
- Simultaneous SOF and EOF (only possible with H_ACTIVE = V_ACTIVE = 1) is treated as SOF followed by EOF on the same pixel.

## Test plan
- Draw a 4x4 blob of 9'h1C0 with its top-left at (100,200) on a black frame, mask 9'h1FF. Required: x_loc = 101, y_loc = 201, found = 1, pix_count = 16, loc_valid pulses exactly once, 3 cycles after pixel (639,479).
- MIN_COUNT = 1 with a single matching pixel at (639,479). Required: x_loc = 639, y_loc = 479, found = 1, pix_count = 1.
- First frame as above, then a frame with only 3 matching pixels. Required on the second report: found = 0, pix_count = 3, x_loc and y_loc held at 101 and 201.
- mask = 9'h1C0 with pixels 9'h1C7 at (10,10) and (20,30), other pixels 9'h03F. Required: x_loc = 15, y_loc = 20, pix_count = 2. In the same frame, matching pixels driven at hcount = 700 must not be counted.
- Assert reset_n = 0 for one cycle mid-frame. Required: no loc_valid that frame, outputs at reset values, and a correct report on the following full frame.
- Drop enable in mid-frame. Required: the current frame still reports. No report follows until enable = 1 is sampled at a later SOF, and that frame then reports normally.
